// File: rtl/xs3_pkg.sv
// Shared constants, state encoding and digit helpers for the excess-3 word sequencer.
package xs3_pkg;

   localparam int DIGIT_W = 4;
   localparam int XS3_W   = 5;

   localparam logic [XS3_W-1:0]   XS3_OFFSET = 5'd3;
   localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;

   // State encoding; the fourth code is unused and recovers to IDLE.
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_CONV = CONV,
      ST_DONE = DONE
   } xs3_state_e;

   // A digit above 9 is not a legal BCD digit.
   function automatic logic digit_out_of_range(input logic [DIGIT_W-1:0] digit);
      return (digit > BCD_MAX);
   endfunction

endpackage

// File: rtl/xs3_digit_conv.sv
// Single combinational BCD-to-excess-3 digit converter, shared across all digit slots.
module xs3_digit_conv
   import xs3_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [XS3_W-1:0]   xs3_o
);

   // Zero-extend then add the offset; 15 + 3 = 18 still fits in five bits.
   assign xs3_o = {1'b0, digit_i} + XS3_OFFSET;

endmodule

// File: rtl/xs3_word_sequencer.sv
// Converts a NIBBLES-digit word to excess-3 one digit per clock through one shared
// converter, with valid/ready handshakes on both the input and output side.
module xs3_word_sequencer
   import xs3_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DIGIT_W*NIBBLES-1:0] in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XS3_W*NIBBLES-1:0]   out_data,
   output logic                       out_err,
   output logic                       busy
);

   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   xs3_state_e                     state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [DIGIT_W*NIBBLES-1:0]     word_q, word_d;
   logic [XS3_W*NIBBLES-1:0]       out_q, out_d;
   logic                           err_q, err_d;

   logic [DIGIT_W-1:0]             digit_s;
   logic [XS3_W-1:0]               conv_s;

   // Select the digit currently being converted from the latched input word.
   always_comb begin
      digit_s = word_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
   end

   xs3_digit_conv u_conv (
      .digit_i (digit_s),
      .xs3_o   (conv_s)
   );

   // Next-state logic: accept in IDLE, one digit per clock in CONV, hold result in DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      out_d   = out_q;
      err_d   = err_q;
      if (flush) begin
         // Abort wins over both handshakes; the result register keeps its contents.
         state_d = ST_IDLE;
         idx_d   = IDX_ZERO;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  word_d  = in_data;
                  idx_d   = IDX_ZERO;
                  err_d   = 1'b0;
                  state_d = ST_CONV;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_CONV: begin
               out_d[int'(idx_q)*XS3_W +: XS3_W] = conv_s;
               err_d = err_q | digit_out_of_range(digit_s);
               if (idx_q == IDX_LAST) begin
                  idx_d   = IDX_ZERO;
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = ST_CONV;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = IDX_ZERO;
            end
         endcase
      end
   end

   // State, index, word, result and error registers; all cleared by the async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= IDX_ZERO;
         word_q  <= {(DIGIT_W*NIBBLES){1'b0}};
         out_q   <= {(XS3_W*NIBBLES){1'b0}};
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   // Handshake and status outputs decode directly from the state register.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      out_data  = out_q;
      out_err   = err_q;
   end

endmodule

// File: tb/tb_xs3_word_sequencer.sv
// Bench for xs3_word_sequencer: directed and random words against an arithmetic model.
module tb_xs3_word_sequencer;

   localparam int N = 4;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_data;
   logic        out_err;
   logic        busy;

   logic        flush1;
   logic        in_valid1;
   logic        in_ready1;
   logic [3:0]  in_data1;
   logic        out_valid1;
   logic        out_ready1;
   logic [4:0]  out_data1;
   logic        out_err1;
   logic        busy1;

   int checks = 0;
   int errors = 0;

   xs3_word_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .busy(busy)
   );

   xs3_word_sequencer #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_err(out_err1), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each digit plus three, placed in its five-bit field.
   function automatic logic [31:0] model_data(input logic [31:0] w, input int n);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < n; i++) begin
         r = r | ((((w >> (4 * i)) & 32'd15) + 32'd3) << (5 * i));
      end
      return r;
   endfunction

   function automatic logic [31:0] model_err(input logic [31:0] w, input int n);
      logic [31:0] e;
      e = 32'd0;
      for (int i = 0; i < n; i++) begin
         if (((w >> (4 * i)) & 32'd15) > 32'd9) e = 32'd1;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the NIBBLES=4 instance, holding out_ready low for 'hold' clocks in DONE.
   task automatic run_word(input logic [15:0] w, input int hold, input string tag);
      logic [31:0] exp_d;
      logic [31:0] exp_e;
      int lat;
      exp_d = model_data(32'(w), N);
      exp_e = model_err(32'(w), N);
      out_ready = (hold == 0);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk({tag, ".latency"}, 32'(lat), 32'(N + 1));
      chk({tag, ".data"}, 32'(out_data), exp_d);
      chk({tag, ".err"}, 32'(out_err), exp_e);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, ".hold"}, {10'd0, out_valid, in_ready, out_data}, {10'd0, 1'b1, 1'b0, exp_d[19:0]});
      end
      out_ready = 1'b1;
      tick();
      chk({tag, ".release"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
      out_ready = 1'b0;
   endtask

   initial begin
      int first_at;
      int second_at;
      int nvalid;
      int overlap;
      int lat;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
      flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'd0; out_ready1 = 1'b1;
      #2;
      chk("reset.state", {27'd0, in_ready, out_valid, out_err, busy, 1'b0}, {27'd0, 5'b10000});
      chk("reset.data", 32'(out_data), 32'd0);
      tick(); tick();
      #4 rst = 1'b0;
      tick();

      // Basic words, including out-of-range digits.
      run_word(16'h1234, 0, "w1234");
      run_word(16'hF9A0, 0, "wF9A0");
      // Consumer stalls for ten clocks in DONE.
      run_word(16'h2468, 10, "stall");

      // Flush at the second conversion clock.
      in_valid = 1'b1; in_data = 16'h5678;
      tick();
      in_valid = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush.idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
      chk("flush.field0", 32'(out_data[4:0]), 32'd11);
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) nvalid++;
      end
      chk("flush.novalid", 32'(nvalid), 32'd0);
      run_word(16'h0000, 0, "w0000");

      // Asynchronous reset between edges while converting.
      in_valid = 1'b1; in_data = 16'h9876;
      tick();
      in_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst.state", {28'd0, in_ready, out_valid, out_err, busy}, {28'd0, 4'b1000});
      chk("arst.data", 32'(out_data), 32'd0);
      #1 rst = 1'b0;
      tick();
      run_word(16'h3150, 1, "post_rst");

      // Back-to-back words with in_valid held high.
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0009;
      tick();
      in_data = 16'h9990;
      first_at = -1; second_at = -1; nvalid = 0; overlap = 0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (busy && in_ready) overlap++;
         if (out_valid) begin
            nvalid++;
            if (nvalid == 1) begin
               first_at = e;
               chk("b2b.data0", 32'(out_data), model_data(32'h0009, N));
               chk("b2b.err0", 32'(out_err), model_err(32'h0009, N));
            end else if (nvalid == 2) begin
               second_at = e;
               in_valid = 1'b0;
               chk("b2b.data1", 32'(out_data), model_data(32'h9990, N));
               chk("b2b.err1", 32'(out_err), model_err(32'h9990, N));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("b2b.first_at", 32'(first_at), 32'(N));
      chk("b2b.second_at", 32'(second_at), 32'(2 * N + 2));
      chk("b2b.count", 32'(nvalid), 32'd2);
      chk("b2b.overlap", 32'(overlap), 32'd0);
      out_ready = 1'b0;
      chk("b2b.idle", 32'(in_ready), 32'd1);

      // Random words with random consumer stalls.
      for (int k = 0; k < 10; k++) begin
         run_word(16'($urandom), int'($urandom_range(0, 3)), "rand");
      end

      // Single-digit build: one conversion clock.
      in_valid1 = 1'b1; in_data1 = 4'h7;
      tick();
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 10) begin
         tick();
         lat++;
      end
      chk("n1.latency", 32'(lat), 32'd2);
      chk("n1.data7", 32'(out_data1), 32'd10);
      chk("n1.err7", 32'(out_err1), 32'd0);
      tick();
      in_valid1 = 1'b1; in_data1 = 4'hC;
      tick();
      in_valid1 = 1'b0;
      tick();
      chk("n1.dataC", {26'd0, out_valid1, out_data1}, {26'd0, 1'b1, 5'd15});
      chk("n1.errC", 32'(out_err1), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
